// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_TS  = 3'd2,
        EVAL   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_checker_read_port.sv
// Avalon-MM read engine: launches a read, holds it under waitrequest and
// aborts it once the stall counter reaches TIMEOUT_CYCLES.
module sysid_read_port
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        launch,
    input  logic        launch_addr,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        rd_timeout
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        read_r;
    logic        addr_r;
    logic [15:0] tmo_cnt_r;
    logic        stall_s;

    assign stall_s     = read_r && avm_waitrequest;
    assign rd_done     = read_r && !avm_waitrequest;
    assign rd_timeout  = stall_s && (tmo_cnt_r >= TMO_LAST);
    assign rd_data     = avm_readdata;
    assign avm_read    = read_r;
    assign avm_address = addr_r;

    // Read strobe, held address and saturating stall counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_r    <= 1'b0;
            addr_r    <= ADDR_ID;
            tmo_cnt_r <= 16'd0;
        end else if (launch) begin
            read_r    <= 1'b1;
            addr_r    <= launch_addr;
            tmo_cnt_r <= 16'd0;
        end else if (rd_done) begin
            read_r    <= 1'b0;
            tmo_cnt_r <= 16'd0;
        end else if (stall_s) begin
            read_r <= !rd_timeout;
            if (tmo_cnt_r != 16'hFFFF) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Boot-time system-ID check: reads ID and timestamp words, retries on failure
// and reports a sticky pass/err status. Optional macro SYSID_CHECKER_PERIODIC_EN
// adds a periodic re-check every PERIOD_CYCLES idle cycles.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd1,
    parameter logic [31:0] EXPECTED_TS    = 32'd1402761306,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_MAX      = 2
`ifdef SYSID_CHECKER_PERIODIC_EN
    ,
    parameter int          PERIOD_CYCLES  = 50_000_000
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  err_code
);

    localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

    state_t      state_r;
    logic        auto_pend_r;
    logic [3:0]  retry_r;
    logic [1:0]  err_pend_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [1:0]  err_code_r;
    logic [31:0] id_value_r;
    logic [31:0] ts_value_r;

    logic        go_s;
    logic        launch_s;
    logic        launch_addr_s;
    logic        rd_done_s;
    logic        rd_timeout_s;
    logic [31:0] rd_data_s;
    logic [1:0]  eval_err_s;
    logic        retry_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_code = err_code_r;
    assign id_value = id_value_r;
    assign ts_value = ts_value_r;

`ifdef SYSID_CHECKER_PERIODIC_EN
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);

    logic [31:0] period_cnt_r;
    logic        period_hit_s;

    assign period_hit_s = (state_r == IDLE) && (period_cnt_r == PERIOD_LAST);
    assign go_s         = auto_pend_r | start | period_hit_s;

    // Idle-time counter; restarts whenever a sequence runs or start is seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt_r <= 32'd0;
        end else if ((state_r != IDLE) || start) begin
            period_cnt_r <= 32'd0;
        end else if (period_cnt_r != 32'hFFFF_FFFF) begin
            period_cnt_r <= period_cnt_r + 32'd1;
        end
    end
`else
    assign go_s = auto_pend_r | start;
`endif

    // Error ranking for the finished attempt: timeout beats ID beats TS.
    always_comb begin
        eval_err_s = ERR_NONE;
        if (err_pend_r == ERR_TIMEOUT) begin
            eval_err_s = ERR_TIMEOUT;
        end else if (id_value_r != EXPECTED_ID) begin
            eval_err_s = ERR_ID;
        end else if (ts_value_r != EXPECTED_TS) begin
            eval_err_s = ERR_TS;
        end else begin
            eval_err_s = ERR_NONE;
        end
    end

    assign retry_s = (eval_err_s != ERR_NONE) && (retry_r < RETRY_LIM);

    // Read launch requests, issued on the edge that enters a read state.
    always_comb begin
        launch_s      = 1'b0;
        launch_addr_s = ADDR_ID;
        case (state_r)
            IDLE: begin
                launch_s      = go_s;
                launch_addr_s = ADDR_ID;
            end
            RD_ID: begin
                launch_s      = rd_done_s;
                launch_addr_s = ADDR_TS;
            end
            EVAL: begin
                launch_s      = retry_s;
                launch_addr_s = ADDR_ID;
            end
            default: begin
                launch_s      = 1'b0;
                launch_addr_s = ADDR_ID;
            end
        endcase
    end

    sysid_read_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read_port (
        .clock           (clock),
        .reset_n         (reset_n),
        .launch          (launch_s),
        .launch_addr     (launch_addr_s),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .rd_done         (rd_done_s),
        .rd_data         (rd_data_s),
        .rd_timeout      (rd_timeout_s)
    );

    // Sequence FSM with registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            auto_pend_r <= 1'b1;
            retry_r     <= 4'd0;
            err_pend_r  <= ERR_NONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_code_r  <= ERR_NONE;
            id_value_r  <= 32'd0;
            ts_value_r  <= 32'd0;
        end else begin
            auto_pend_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (go_s) begin
                        state_r    <= RD_ID;
                        retry_r    <= 4'd0;
                        err_pend_r <= ERR_NONE;
                        busy_r     <= 1'b1;
                    end
                end
                RD_ID: begin
                    if (rd_done_s) begin
                        id_value_r <= rd_data_s;
                        state_r    <= RD_TS;
                    end else if (rd_timeout_s) begin
                        err_pend_r <= ERR_TIMEOUT;
                        state_r    <= EVAL;
                    end
                end
                RD_TS: begin
                    if (rd_done_s) begin
                        ts_value_r <= rd_data_s;
                        state_r    <= EVAL;
                    end else if (rd_timeout_s) begin
                        err_pend_r <= ERR_TIMEOUT;
                        state_r    <= EVAL;
                    end
                end
                EVAL: begin
                    if (retry_s) begin
                        retry_r    <= retry_r + 4'd1;
                        err_pend_r <= ERR_NONE;
                        state_r    <= RD_ID;
                    end else begin
                        pass_r     <= (eval_err_s == ERR_NONE);
                        err_code_r <= eval_err_s;
                        done_r     <= 1'b1;
                        state_r    <= FINISH;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized bench for sysid_checker: a reactive Avalon slave plus a
// sequence-level model of reads, retries, latency and final status.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd1;
    localparam logic [31:0] EXP_TS = 32'd1402761306;
    localparam int          TMO    = 8;
    localparam int          RMAX   = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave behaviour for the current sequence.
    logic [31:0] cfg_id    = EXP_ID;
    logic [31:0] cfg_ts    = EXP_TS;
    int          cfg_stall = 0;
    bit          cfg_stuck = 1'b0;

    // Model state: last captured words.
    logic [31:0] m_id = 32'd0;
    logic [31:0] m_ts = 32'd0;

    logic addr_q[$];
    bit   in_read = 1'b0;
    int   stall_left = 0;
    logic rd_addr = 1'b0;

    sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .RETRY_MAX      (RMAX)
`ifdef SYSID_CHECKER_PERIODIC_EN
        ,
        .PERIOD_CYCLES  (20)
`endif
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .err_code        (err_code)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reactive slave: logs each read address, stalls, and checks hold stability.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n || !avm_read) begin
                in_read         = 1'b0;
                avm_waitrequest = 1'b0;
                avm_readdata    = $urandom;
            end else begin
                if (!in_read) begin
                    in_read    = 1'b1;
                    stall_left = cfg_stall;
                    rd_addr    = avm_address;
                    addr_q.push_back(avm_address);
                end else begin
                    check_eq("addr_hold", avm_address, rd_addr);
                end
                if (cfg_stuck || stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    if (stall_left > 0) stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = avm_address ? cfg_ts : cfg_id;
                    in_read         = 1'b0;
                end
            end
        end
    end

    // Runs one sequence; the launch edge is the next posedge.
    task automatic run_seq(input bit ext_start);
        int   err;
        int   per;
        int   attempts;
        int   exp_done;
        int   done_at;
        int   inj;
        logic exp_q[$];
        if (cfg_stuck) begin
            err = 3;
            per = TMO + 1;
        end else begin
            err = (cfg_id != EXP_ID) ? 1 : ((cfg_ts != EXP_TS) ? 2 : 0);
            per = 2 * (cfg_stall + 1) + 1;
            m_id = cfg_id;
            m_ts = cfg_ts;
        end
        attempts = (err != 0) ? RMAX + 1 : 1;
        exp_done = attempts * per + 1;
        for (int a = 0; a < attempts; a++) begin
            exp_q.push_back(1'b0);
            if (!cfg_stuck) exp_q.push_back(1'b1);
        end
        addr_q.delete();
        inj     = $urandom_range(exp_done, 1);
        done_at = 0;
        start   = ext_start;
        for (int n = 1; n <= exp_done + 20 && done_at == 0; n++) begin
            @(negedge clock);
            start = (n == inj);
            if (n == 1) check_eq("busy_on", busy, 1);
            if (done) done_at = n;
        end
        check_eq("done_cycle", done_at, exp_done);
        check_eq("pass", pass, (err == 0));
        check_eq("err_code", err_code, err);
        check_eq("id_value", id_value, m_id);
        check_eq("ts_value", ts_value, m_ts);
        check_eq("n_reads", addr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < addr_q.size(); i++) begin
            check_eq("addr_seq", addr_q[i], exp_q[i]);
        end
        @(negedge clock);
        start = 1'b0;
        check_eq("done_pulse", done, 0);
        check_eq("busy_idle", busy, 0);
        repeat (2) begin
            @(negedge clock);
            check_eq("no_requeue", {busy, avm_read}, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass, 0);
        check_eq("rst_err", err_code, 0);
        check_eq("rst_id", id_value, 0);
        check_eq("rst_ts", ts_value, 0);
        check_eq("rst_read", {avm_read, avm_address}, 0);
        reset_n = 1'b1;
        run_seq(1'b0);

        cfg_id = 32'd2;
        run_seq(1'b1);
        cfg_id    = EXP_ID;
        cfg_stall = 3;
        run_seq(1'b1);
        cfg_stuck = 1'b1;
        run_seq(1'b1);
        cfg_stuck = 1'b0;
        cfg_stall = 1;
        cfg_ts    = EXP_TS + 32'd1;
        run_seq(1'b1);

        // Reset while the ID read is stalled.
        cfg_ts    = EXP_TS;
        cfg_stall = 3;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_read", {avm_read, avm_address}, 0);
        check_eq("mid_rst_stat", {busy, done, pass, err_code}, 0);
        check_eq("mid_rst_id", id_value, 0);
        check_eq("mid_rst_ts", ts_value, 0);
        @(negedge clock);
        reset_n = 1'b1;
        m_id = 32'd0;
        m_ts = 32'd0;
        run_seq(1'b0);

        for (int k = 0; k < 25; k++) begin
            cfg_id    = ($urandom_range(9, 0) < 7) ? EXP_ID : (EXP_ID ^ (32'h1 << $urandom_range(31, 0)));
            cfg_ts    = ($urandom_range(9, 0) < 7) ? EXP_TS : (EXP_TS ^ (32'h1 << $urandom_range(31, 0)));
            cfg_stall = $urandom_range(3, 0);
            cfg_stuck = ($urandom_range(7, 0) == 0);
            run_seq(1'b1);
        end

`ifdef SYSID_CHECKER_PERIODIC_EN
        begin
            int j;
            j = 3;
            while (!busy && j < 100) begin
                @(negedge clock);
                j++;
            end
            check_eq("period_launch", j, 21);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
